// File: rtl/lfsr_chk_pkg.sv
// Shared types and step functions for the LFSR stream checker and its stimulus generator.
// Both ends call lfsr_next so the generator and the checker always use the same polynomial.
package lfsr_chk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int          LFSR_MAX_W   = 64;
    localparam logic [15:0] ERR_IDX_NONE = 16'hFFFF;

    // Shift left by one and insert x[w-1]^x[2]^x[0] at bit 0, using only the low w bits.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] x,
                                                        input int                    w);
        logic [LFSR_MAX_W-1:0] mask;
        logic [LFSR_MAX_W-1:0] taps;
        logic                  fb;
        mask = (w >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << w) - LFSR_MAX_W'(1));
        taps = (LFSR_MAX_W'(1) << (w - 1)) | LFSR_MAX_W'(5);
        fb   = ^(x & taps);
        return ((x << 1) & mask) | LFSR_MAX_W'(fb);
    endfunction

    function automatic logic [LFSR_MAX_W-1:0] misr_next(input logic [LFSR_MAX_W-1:0] sig,
                                                        input logic [LFSR_MAX_W-1:0] data,
                                                        input int                    w);
        return data ^ lfsr_next(sig, w);
    endfunction

endpackage

// File: rtl/lfsr_stream_checker.sv
// Checks a valid/ready word stream against a regenerated LFSR sequence and compacts it into a MISR.
// Latency: done/pass valid the cycle after the last accepted beat.
// Backpressure: in_ready is high for the whole of RUN, independent of in_valid.
module lfsr_stream_checker
    import lfsr_chk_pkg::*;
#(
    parameter int          WIDTH     = 64,
    parameter int          NUM_WORDS = 100,
    parameter logic [63:0] SEED      = 64'h5aef0c8d_d70a4497
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx,
    output logic [WIDTH-1:0] signature
);

    localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
    localparam logic [15:0]      LAST_IDX = 16'(NUM_WORDS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] expected_q;
    logic [15:0]      cnt_q;
    logic             accept;
    logic             clear;
    logic             mismatch;
    logic             last_beat;

    assign in_ready  = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = (state_q == DONE) && (err_count == 16'd0);
    assign accept    = in_valid && in_ready;
    assign clear     = start && (state_q != RUN);
    assign mismatch  = (in_data != expected_q);
    assign last_beat = (cnt_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (accept && last_beat) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Expected word advances on every accept, mismatch or not: no resync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected_q    <= SEED_W;
            cnt_q         <= 16'd0;
            err_count     <= 16'd0;
            first_err_idx <= ERR_IDX_NONE;
            signature     <= '0;
        end else if (clear) begin
            expected_q    <= SEED_W;
            cnt_q         <= 16'd0;
            err_count     <= 16'd0;
            first_err_idx <= ERR_IDX_NONE;
            signature     <= '0;
        end else if (accept) begin
            expected_q <= WIDTH'(lfsr_next(LFSR_MAX_W'(expected_q), WIDTH));
            signature  <= WIDTH'(misr_next(LFSR_MAX_W'(signature), LFSR_MAX_W'(in_data), WIDTH));
            cnt_q      <= cnt_q + 16'd1;
            if (mismatch) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (first_err_idx == ERR_IDX_NONE) begin
                    first_err_idx <= cnt_q;
                end
            end
        end
    end

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
Receive-side counterpart of the LFSR stimulus generator used in our self-checking benches. It consumes a valid/ready stream of words and checks each beat against a locally regenerated LFSR sequence from a fixed seed. It compacts every accepted word into a MISR signature and reports pass/fail after a programmed number of beats. It sits at the far end of a bench data path, replacing per-cycle `$stop` checks inside tests.

Parameters:
WIDTH, 64, data/LFSR/signature width (>= 4)
NUM_WORDS, 100, beats accepted per run (>= 1, < 65536)
SEED, 64'h5aef0c8d_d70a4497, expected value of beat 0 (truncated to WIDTH)

Ports:
clk  input  1  single clock, all state on posedge
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a run from IDLE or DONE
in_valid  input  1  upstream beat valid
in_data  input  WIDTH  upstream beat payload
in_ready  output  1  checker accepts a beat this cycle
busy  output  1  high in RUN
done  output  1  high in DONE
pass  output  1  in DONE: err_count==0; else 0
err_count  output  16  mismatching beats this run, saturates at 16'hFFFF
first_err_idx  output  16  beat index of first mismatch; 16'hFFFF if none
signature  output  WIDTH  MISR state

Behaviour:
- Async reset (rst_n low): state=IDLE; in_ready=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=16'hFFFF, signature=0; expected=SEED; beat counter=0.
- LFSR step: lfsr(x) = {x[W-2:0], x[W-1]^x[2]^x[0]}.
- MISR step: sig' = in_data ^ lfsr(sig).
- FSM IDLE -> RUN on start.
  - Entry to RUN clears err_count, sets first_err_idx=FFFF, signature=0, expected=SEED, counter=0.
- RUN: in_ready=1 combinationally from state only, never from in_valid.
  - Accept = in_valid & in_ready.
  - On accept: compare in_data to expected. On mismatch, err_count += 1 (saturating). If first_err_idx==FFFF, latch the counter into it.
  - Also on accept: expected <= lfsr(expected); signature <= MISR step; counter += 1.
  - expected always advances, even on mismatch. There is no resync.
  - No accept means no state change. Bubbles are allowed at any point.
- RUN -> DONE in the cycle after the accept where counter==NUM_WORDS-1. No extra latency.
  - done/pass are registered, valid the first cycle in DONE.
- DONE: in_ready=0; outputs hold.
  - start in DONE re-enters RUN, with the same clear as IDLE -> RUN.
- start while in RUN is ignored; the run continues unaffected.
- start together with in_valid in IDLE/DONE: the beat is not accepted that cycle (in_ready=0). Acceptance begins the next cycle.
- Reset mid-run: immediate return to the reset values; the partial run is discarded.
- err_count saturation: stays at FFFF, and first_err_idx is unaffected.

Decomposition:
- Package lfsr_chk_pkg holds:
  - enum state_t {IDLE, RUN, DONE}
  - function lfsr_next(x), width-generic via a WIDTH-sized logic vector
  - function misr_next(sig, data)
  - localparam ERR_IDX_NONE = 16'hFFFF
- No sub-module is needed. The datapath stays in one module, with the FSM in one always_ff plus combinational in_ready/pass.
- The bench's generator reuses lfsr_next from the package so both ends share one polynomial.

Test Plan:
- Reset, start, 100 correct beats with no bubbles -> in_ready high cycles 1..100 after start; done=1, pass=1, err_count=0, first_err_idx=FFFF.
- NUM_WORDS=2, beats 5aef0c8dd70a4497 then b5de191bae14892e:
  - signature after beat 0 = 5aef0c8dd70a4497
  - signature after beat 1 = 0
  - pass=1
- Corrupt beat 7 (flip bit 0), rest correct -> err_count=1, first_err_idx=7, pass=0. Beat 8 is still checked against the unflipped sequence and counts no error.
- Random in_valid at 30% duty, correct data -> identical final signature and pass as the no-bubble case. in_ready stays 1 throughout RUN.
- Drop rst_n at beat 50, release, start again -> outputs return to reset values immediately. The new run from SEED passes with 100 beats.
- start pulse mid-run, and start in DONE -> the mid-run pulse has no effect. The pulse in DONE restarts, with err_count cleared and done deasserted the next cycle.
